// File: rtl/noc_local_input_port_if.sv
// noc_local_input_port_if: PE flit/credit and allocator/crossbar signals of a router local input port.
interface noc_local_input_port_if;
  logic [19:0] datain;
  logic        in_valid;
  logic        co;
  logic [4:0]  route_req;
  logic        grant;
  logic [19:0] flit_out;
  logic        flit_out_valid;
  logic        err;
  modport master (output datain, in_valid, grant, input co, route_req, flit_out, flit_out_valid, err);
  modport slave (input datain, in_valid, grant, output co, route_req, flit_out, flit_out_valid, err);
endinterface

// File: rtl/noc_local_input_port.sv
// noc_local_input_port: credit-flow flit buffer with XY route computation and per-packet output request.
module noc_local_input_port #(
  parameter int DEPTH = 4,
  parameter int X_ID  = 0,
  parameter int Y_ID  = 0
) (
  input logic clk,
  input logic RST,
  noc_local_input_port_if.slave p
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t          r_state, w_next;
  logic [19:0]     r_mem [DEPTH];
  logic [AW-1:0]   r_wp, r_rp;
  logic [CW-1:0]   r_cnt;
  logic [4:0]      r_port, w_route;
  logic [19:0]     r_fo, w_head;
  logic            r_fov, r_co, r_err;
  logic            w_nempty, w_full, w_push, w_pop, w_fwd, w_latch, w_drop;
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] v);
    return v == AW'(DEPTH - 1) ? '0 : v + 1'b1;
  endfunction
  assign w_head   = r_mem[r_rp];
  assign w_nempty = r_cnt != '0;
  assign w_full   = r_cnt == CW'(DEPTH);
  // X is resolved before Y so packets cannot deadlock on turns
  assign w_route  = w_head[15:14] > 2'(X_ID) ? 5'b00100 :
                    w_head[15:14] < 2'(X_ID) ? 5'b10000 :
                    w_head[17:16] > 2'(Y_ID) ? 5'b01000 :
                    w_head[17:16] < 2'(Y_ID) ? 5'b00010 : 5'b00001;
  always_comb begin
    w_next  = r_state;
    w_latch = 1'b0;
    w_drop  = 1'b0;
    w_fwd   = 1'b0;
    if (r_state == IDLE) begin
      w_latch = w_nempty && !w_head[19];
      w_drop  = w_nempty && w_head[19];
      w_next  = w_latch ? ACTIVE : IDLE;
    end else begin
      w_fwd  = p.grant && w_nempty;
      w_next = (w_fwd && w_head[19] == w_head[18]) ? IDLE : ACTIVE;
    end
  end
  assign w_pop  = w_fwd || w_drop;
  assign w_push = p.in_valid && (!w_full || w_pop);
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_state <= IDLE;
      r_port  <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
      r_co    <= 1'b0;
      r_fov   <= 1'b0;
      r_fo    <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_latch) r_port <= w_route;
      if (w_push) r_wp <= inc(r_wp);
      if (w_pop) r_rp <= inc(r_rp);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      r_co  <= w_pop;
      r_fov <= w_fwd;
      if (w_fwd) r_fo <= w_head;
      if (w_drop || (p.in_valid && !w_push)) r_err <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= p.datain;
  end
  assign p.route_req      = (r_state == ACTIVE && w_nempty) ? r_port : 5'b0;
  assign p.co             = r_co;
  assign p.flit_out       = r_fo;
  assign p.flit_out_valid = r_fov;
  assign p.err            = r_err;
endmodule

// File: tb/tb_noc_local_input_port.sv
// tb_noc_local_input_port: directed checks of buffering, XY routing, credits and errors at router (1,1).
module tb_noc_local_input_port;
  logic clk;
  logic RST;
  int   errors;
  int   checks;
  int   co_cnt;
  logic [19:0] outq[$];
  logic [19:0] fl[10];
  noc_local_input_port_if bus();
  noc_local_input_port #(.DEPTH(4), .X_ID(1), .Y_ID(1)) dut (.clk(clk), .RST(RST), .p(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bus.co) co_cnt++;
    if (bus.flit_out_valid) outq.push_back(bus.flit_out);
  end
  initial begin
    #100000;
    $display("FAIL watchdog: sim time exceeded, got timeout exp completion");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic ck;
    @(posedge clk);
    #1;
  endtask
  task automatic clr;
    co_cnt = 0;
    outq.delete();
  endtask
  task automatic do_reset;
    bus.in_valid = 1'b0;
    bus.grant    = 1'b0;
    bus.datain   = '0;
    RST = 1'b0;
    ck;
    ck;
    RST = 1'b1;
    ck;
    clr;
  endtask
  task automatic push(input logic [19:0] f);
    bus.datain   = f;
    bus.in_valid = 1'b1;
    ck;
    bus.in_valid = 1'b0;
  endtask
  initial begin
    errors = 0;
    checks = 0;
    co_cnt = 0;
    do_reset;
    chk("rst_req", 32'(bus.route_req), 32'h0);
    chk("rst_co", 32'(bus.co), 32'h0);
    chk("rst_fov", 32'(bus.flit_out_valid), 32'h0);
    chk("rst_fo", 32'(bus.flit_out), 32'h0);
    chk("rst_err", 32'(bus.err), 32'h0);
    push(20'h08ABC);
    ck;
    chk("single_req", 32'(bus.route_req), 32'h04);
    bus.grant = 1'b1;
    ck;
    bus.grant = 1'b0;
    chk("single_fov", 32'(bus.flit_out_valid), 32'h1);
    chk("single_fo", 32'(bus.flit_out), 32'h08ABC);
    chk("single_co", 32'(bus.co), 32'h1);
    chk("single_req_drop", 32'(bus.route_req), 32'h0);
    ck;
    chk("single_fov_end", 32'(bus.flit_out_valid), 32'h0);
    chk("single_co_end", 32'(bus.co), 32'h0);
    chk("single_co_cnt", 32'(co_cnt), 32'd1);
    chk("single_out_cnt", 32'(outq.size()), 32'd1);
    clr;
    fl[0] = 20'h74001; fl[1] = 20'h80002; fl[2] = 20'h80003; fl[3] = 20'hC0004;
    for (int i = 0; i < 4; i++) push(fl[i]);
    chk("pkt4_req", 32'(bus.route_req), 32'h08);
    bus.grant = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("pkt4_req_hold", 32'(bus.route_req), 32'h08);
      ck;
      chk("pkt4_fo", 32'(bus.flit_out), 32'(fl[i]));
      chk("pkt4_fov", 32'(bus.flit_out_valid), 32'h1);
    end
    bus.grant = 1'b0;
    chk("pkt4_req_after_tail", 32'(bus.route_req), 32'h0);
    ck;
    chk("pkt4_co_cnt", 32'(co_cnt), 32'd4);
    chk("pkt4_fov_end", 32'(bus.flit_out_valid), 32'h0);
    do_reset;
    fl[0] = 20'h50011; fl[1] = 20'h80012; fl[2] = 20'h80013; fl[3] = 20'hC0014; fl[4] = 20'h80015;
    for (int i = 0; i < 5; i++) push(fl[i]);
    chk("ovf_err", 32'(bus.err), 32'h1);
    chk("ovf_req", 32'(bus.route_req), 32'h10);
    bus.grant = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ck;
      chk("ovf_fo", 32'(bus.flit_out), 32'(fl[i]));
    end
    bus.grant = 1'b0;
    ck;
    chk("ovf_req_end", 32'(bus.route_req), 32'h0);
    chk("ovf_out_cnt", 32'(outq.size()), 32'd4);
    chk("ovf_co_cnt", 32'(co_cnt), 32'd4);
    chk("ovf_fov_end", 32'(bus.flit_out_valid), 32'h0);
    do_reset;
    push(20'h80033);
    chk("drop_err_pre", 32'(bus.err), 32'h0);
    chk("drop_co_pre", 32'(bus.co), 32'h0);
    ck;
    chk("drop_err", 32'(bus.err), 32'h1);
    chk("drop_co", 32'(bus.co), 32'h1);
    chk("drop_fov", 32'(bus.flit_out_valid), 32'h0);
    ck;
    chk("drop_co_end", 32'(bus.co), 32'h0);
    chk("drop_fov_end", 32'(bus.flit_out_valid), 32'h0);
    chk("drop_req", 32'(bus.route_req), 32'h0);
    chk("drop_co_cnt", 32'(co_cnt), 32'd1);
    chk("drop_out_cnt", 32'(outq.size()), 32'd0);
    do_reset;
    fl[0] = 20'h58021;
    for (int i = 1; i < 9; i++) fl[i] = 20'h80021 + 20'(i);
    fl[9] = 20'hC002A;
    for (int i = 0; i < 4; i++) push(fl[i]);
    chk("full_req", 32'(bus.route_req), 32'h04);
    for (int i = 0; i < 6; i++) begin
      bus.datain   = fl[4+i];
      bus.in_valid = 1'b1;
      bus.grant    = 1'b1;
      ck;
      chk("full_fo", 32'(bus.flit_out), 32'(fl[i]));
      chk("full_fov", 32'(bus.flit_out_valid), 32'h1);
    end
    bus.in_valid = 1'b0;
    chk("full_err", 32'(bus.err), 32'h0);
    chk("full_req_mid", 32'(bus.route_req), 32'h04);
    for (int i = 6; i < 10; i++) begin
      ck;
      chk("full_drain_fo", 32'(bus.flit_out), 32'(fl[i]));
    end
    bus.grant = 1'b0;
    chk("full_req_end", 32'(bus.route_req), 32'h0);
    ck;
    chk("full_out_cnt", 32'(outq.size()), 32'd10);
    chk("full_co_cnt", 32'(co_cnt), 32'd10);
    for (int i = 0; i < 10; i++) chk("full_order", 32'(outq[i]), 32'(fl[i]));
    clr;
    push(20'h50011);
    push(20'h80012);
    push(20'h80013);
    chk("mid_req", 32'(bus.route_req), 32'h10);
    #2 RST = 1'b0;
    #1;
    chk("mid_rst_req", 32'(bus.route_req), 32'h0);
    chk("mid_rst_co", 32'(bus.co), 32'h0);
    chk("mid_rst_fov", 32'(bus.flit_out_valid), 32'h0);
    chk("mid_rst_fo", 32'(bus.flit_out), 32'h0);
    chk("mid_rst_err", 32'(bus.err), 32'h0);
    ck;
    ck;
    RST = 1'b1;
    ck;
    ck;
    chk("mid_no_credit", 32'(co_cnt), 32'd0);
    chk("mid_empty_req", 32'(bus.route_req), 32'h0);
    push(20'h14077);
    ck;
    chk("local_req", 32'(bus.route_req), 32'h01);
    bus.grant = 1'b1;
    ck;
    bus.grant = 1'b0;
    chk("local_fo", 32'(bus.flit_out), 32'h14077);
    chk("local_fov", 32'(bus.flit_out_valid), 32'h1);
    ck;
    chk("local_co_cnt", 32'(co_cnt), 32'd1);
    chk("local_req_end", 32'(bus.route_req), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/noc_local_input_port.md
Name: noc_local_input_port

Overview:
Router-side local input port that consumes flits from the attached processor element. It buffers up to DEPTH 20-bit flits and returns one credit per freed slot on co, which drives the PE's ci. It performs XY route computation on each head flit and holds a one-hot output-port request until the packet's tail has been granted through the crossbar.

Parameters:
DEPTH, 4, flit buffer slots; equals the credit count the PE starts with
X_ID, 0, this router's mesh column (0..3)
Y_ID, 0, this router's mesh row (0..3)

Ports:
clk  input  1  clock
RST  input  1  asynchronous, active-low reset
datain  input  20  flit from PE
in_valid  input  1  datain valid; one flit written per cycle
co  output  1  credit return to PE (PE ci); one-cycle pulse per freed slot
route_req  output  5  one-hot request to switch allocator; bit0 L, bit1 N, bit2 E, bit3 S, bit4 W
grant  input  1  allocator grant for route_req; pops the head flit this cycle
flit_out  output  20  flit toward crossbar
flit_out_valid  output  1  flit_out valid
err  output  1  sticky protocol/overflow error

Behaviour:
- Flit format:
  - [19:18] type: 00 single (head+tail), 01 head, 10 body, 11 tail.
  - Head/single [17:14] = dest id, where dest_x = [15:14] and dest_y = [17:16].
  - [13:0] payload, untouched.
- Reset (async, RST=0): FIFO empty, state IDLE, route_req=0, co=0, flit_out=0, flit_out_valid=0, err=0. Reset mid-packet discards all buffered flits and issues no credits.
- FIFO:
  - Circular buffer with a count of width clog2(DEPTH)+1.
  - Push when in_valid.
  - Pop when grant && state==ACTIVE && count>0, or on a drop in IDLE.
  - Push and pop in the same cycle: count unchanged, pointers both advance. Pointers wrap modulo DEPTH.
  - Push while count==DEPTH and no same-cycle pop: flit discarded, err set. Credit discipline makes this a protocol violation.
- Credits: co=1 in the cycle after every pop, whether forwarded or dropped. Exactly one co pulse per popped flit; never pulsed otherwise.
- Route computation (combinational on the head flit dest):
  - dest_x>X_ID -> E; dest_x<X_ID -> W.
  - Otherwise dest_y>Y_ID -> S; dest_y<Y_ID -> N.
  - Otherwise L.
- State machine:
  - IDLE:
    - If count>0 and head type is 01 or 00: latch the route into out_port and go to ACTIVE. No pop.
    - If count>0 and head type is 10 or 11: pop and drop the flit, set err, stay IDLE.
  - ACTIVE:
    - route_req = out_port when count>0, else 0. This includes the cycle after the last buffered flit leaves mid-packet.
    - grant while route_req=0 is ignored.
    - On accepted grant: pop; next cycle flit_out = popped flit and flit_out_valid=1; otherwise flit_out_valid=0 and flit_out holds its value.
    - If the popped flit is type 11 or 00: next state IDLE, route_req drops the next cycle.
- Latency:
  - In_valid at cycle t makes the flit visible at the FIFO head at t+1.
  - For a head flit: state goes ACTIVE at t+2 and route_req is asserted from t+2.
  - Grant at cycle g gives flit_out_valid and co at g+1.
- A new head flit queued behind a tail is routed only after returning to IDLE. There is a minimum one-cycle bubble between packets.
- err clears only on reset.

Test Plan:
- Single-flit packet: X_ID=1, Y_ID=1, datain=20'h0_8ABC (type 00, dest x=2, y=0), grant at first route_req -> route_req=5'b00100 (E); flit_out=20'h08ABC valid for 1 cycle; one co pulse; back to IDLE.
- 4-flit packet (head dest x=1, y=3 at router 1,1, then 2 body, tail), grant held high -> route_req=5'b01000 (S) for 4 grant cycles; flit_out in order; 4 co pulses; route_req=0 after the tail.
- Fill to DEPTH=4 with grant low, then a 5th in_valid -> err=1; 5th flit lost; after granting, exactly 4 flits out and 4 co pulses.
- Full FIFO with simultaneous in_valid and grant for 6 cycles -> no err; count stays 4; 6 flits out in order.
- Body flit arriving in IDLE -> dropped, co pulse the next cycle, err=1, flit_out_valid stays 0.
- RST low mid-packet with 3 flits buffered -> all outputs 0 immediately; no co pulses; after release a new head packet routes correctly (dest == own id -> route_req=5'b00001).
